// File: rtl/lsu_mmio_bridge_pkg.sv
// Shared constants, types and helpers for the LSU-side MMIO bridge.
package lsu_mmio_bridge_pkg;

   localparam int unsigned DW                 = 64;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

   localparam logic [DW-1:0] CLINT_BASE_ADDR = 64'h0000_0000_0200_0000;
   localparam logic [DW-1:0] DMEM_BASE_ADDR  = 64'h0000_0000_8000_0000;
   localparam logic [DW-1:0] MMIO_MTIME      = 64'h0000_0000_0200_BFF8;
   localparam logic [DW-1:0] MMIO_MTIMECMP   = 64'h0000_0000_0200_4000;

   // log2 of the window sizes: CLINT 64 KiB, DMEM 128 MiB
   localparam int unsigned CLINT_WIN_BITS = 16;
   localparam int unsigned DMEM_WIN_BITS  = 27;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_D  = 3'd3;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   localparam logic [2:0] F3_WU = 3'd6;

   localparam logic READ_EN  = 1'b1;
   localparam logic WRITE_EN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLINT_ACC,
      ST_MEM_REQ,
      ST_MEM_WAIT,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [2:0]    size;
      logic          wen;
   } lsu_req_t;

   // Low address bits that must be zero for a naturally aligned access
   function automatic logic [2:0] align_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'b000;
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] strb_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load shift plus sign/zero extension, store strobes and data shift.
module lsu_lane_align
   import lsu_mmio_bridge_pkg::*;
(
   input  logic [2:0]    addr_lo_i,
   input  logic [2:0]    size_i,
   input  logic [DW-1:0] rdata_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] load_data_c,
   output logic [7:0]    wstrb_c,
   output logic [DW-1:0] wdata_c
);

   logic [5:0]    shamt;
   logic [DW-1:0] shifted;

   always_comb begin
      shamt       = {addr_lo_i, 3'b000};
      shifted     = rdata_i >> shamt;
      load_data_c = shifted;
      case (size_i)
         F3_B:    load_data_c = {{(DW-8){shifted[7]}}, shifted[7:0]};
         F3_H:    load_data_c = {{(DW-16){shifted[15]}}, shifted[15:0]};
         F3_W:    load_data_c = {{(DW-32){shifted[31]}}, shifted[31:0]};
         F3_BU:   load_data_c = DW'(shifted[7:0]);
         F3_HU:   load_data_c = DW'(shifted[15:0]);
         F3_WU:   load_data_c = DW'(shifted[31:0]);
         default: load_data_c = shifted;
      endcase
      wstrb_c = strb_mask(size_i[1:0]) << addr_lo_i;
      wdata_c = wdata_i << shamt;
   end

endmodule

// File: rtl/lsu_mmio_bridge.sv
// Single-outstanding LSU bridge routing loads/stores to the CLINT register port or the data-memory bus.
module lsu_mmio_bridge
   import lsu_mmio_bridge_pkg::*;
#(
   parameter int unsigned   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [DW-1:0] CLINT_BASE     = CLINT_BASE_ADDR,
   parameter logic [DW-1:0] DMEM_BASE      = DMEM_BASE_ADDR
) (
   input  logic          lsu_clk_i,
   input  logic          lsu_rst_i,
   input  logic          lsu_req_valid_i,
   output logic          lsu_req_ready_o,
   input  logic [DW-1:0] lsu_addr_i,
   input  logic          lsu_wen_i,
   input  logic [DW-1:0] lsu_wdata_i,
   input  logic [2:0]    lsu_size_i,
   output logic          lsu_resp_valid_o,
   output logic [DW-1:0] lsu_rdata_o,
   output logic          lsu_resp_err_o,
   output logic          clint_ren_o,
   output logic          clint_wen_o,
   output logic [DW-1:0] clint_rwaddr_o,
   output logic [DW-1:0] clint_wdata_o,
   input  logic [DW-1:0] clint_rdata_i,
   output logic          dmem_req_valid_o,
   input  logic          dmem_req_ready_i,
   output logic [DW-1:0] dmem_addr_o,
   output logic          dmem_wen_o,
   output logic [7:0]    dmem_wstrb_o,
   output logic [DW-1:0] dmem_wdata_o,
   input  logic          dmem_rvalid_i,
   input  logic [DW-1:0] dmem_rdata_i
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   state_e        state_q, state_d;
   lsu_req_t      req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept, misaligned, bad_size, in_clint, in_dmem, timeout;

   logic          ready_q, ready_d, resp_valid_q, resp_valid_d, err_q, err_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          clint_ren_q, clint_ren_d, clint_wen_q, clint_wen_d;
   logic [DW-1:0] clint_addr_q, clint_addr_d, clint_wdata_q, clint_wdata_d;
   logic          dmem_valid_q, dmem_valid_d, dmem_wen_q, dmem_wen_d;
   logic [DW-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
   logic [7:0]    dmem_wstrb_q, dmem_wstrb_d;

   logic [DW-1:0] load_c, wdata_c;
   logic [7:0]    wstrb_c;

   // Request latch; ready_q is high exactly in IDLE
   always_comb begin
      accept = lsu_req_valid_i & ready_q;
      req_d  = req_q;
      if (accept) begin
         req_d = '{addr: lsu_addr_i, wdata: lsu_wdata_i, size: lsu_size_i, wen: lsu_wen_i};
      end
   end

   lsu_lane_align u_lane_align (
      .addr_lo_i   (req_d.addr[2:0]),
      .size_i      (req_d.size),
      .rdata_i     ((state_q == ST_CLINT_ACC) ? clint_rdata_i : dmem_rdata_i),
      .wdata_i     (req_d.wdata),
      .load_data_c (load_c),
      .wstrb_c     (wstrb_c),
      .wdata_c     (wdata_c)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      misaligned = |(lsu_addr_i[2:0] & align_mask(lsu_size_i[1:0]));
      bad_size   = (lsu_size_i == 3'd7);
      in_clint   = (lsu_addr_i >> CLINT_WIN_BITS) == (CLINT_BASE >> CLINT_WIN_BITS);
      in_dmem    = (lsu_addr_i >> DMEM_WIN_BITS) == (DMEM_BASE >> DMEM_WIN_BITS);
      timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rdata_d = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (misaligned || bad_size) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end else if (in_clint) begin
                  if (lsu_size_i == F3_D) begin
                     state_d = ST_CLINT_ACC;
                  end else begin
                     state_d = ST_RESP;
                     err_d   = 1'b1;
                  end
               end else if (in_dmem) begin
                  state_d = ST_MEM_REQ;
               end else begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end
            end
         end
         ST_CLINT_ACC: begin
            if (!req_q.wen) rdata_d = load_c;
            state_d = ST_RESP;
         end
         ST_MEM_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_req_ready_i) begin
               state_d = req_q.wen ? ST_RESP : ST_MEM_WAIT;
            end else if (timeout) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_rvalid_i) begin
               rdata_d = load_c;
               state_d = ST_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Output flops follow the state being entered
      ready_d       = (state_d == ST_IDLE);
      resp_valid_d  = (state_d == ST_RESP);
      clint_ren_d   = (state_d == ST_CLINT_ACC && !req_d.wen) ? READ_EN : ~READ_EN;
      clint_wen_d   = (state_d == ST_CLINT_ACC && req_d.wen) ? WRITE_EN : ~WRITE_EN;
      clint_addr_d  = (state_d == ST_CLINT_ACC) ? req_d.addr : '0;
      clint_wdata_d = (state_d == ST_CLINT_ACC && req_d.wen) ? req_d.wdata : '0;
      dmem_valid_d  = (state_d == ST_MEM_REQ);
      dmem_wen_d    = (state_d == ST_MEM_REQ) && req_d.wen;
      dmem_addr_d   = (state_d == ST_MEM_REQ) ? {req_d.addr[DW-1:3], 3'b000} : '0;
      dmem_wstrb_d  = dmem_wen_d ? wstrb_c : '0;
      dmem_wdata_d  = dmem_wen_d ? wdata_c : '0;
   end

   always_ff @(posedge lsu_clk_i or posedge lsu_rst_i) begin
      if (lsu_rst_i) begin
         state_q       <= ST_IDLE;
         req_q         <= '0;
         cnt_q         <= '0;
         ready_q       <= 1'b1;
         resp_valid_q  <= 1'b0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         clint_ren_q   <= 1'b0;
         clint_wen_q   <= 1'b0;
         clint_addr_q  <= '0;
         clint_wdata_q <= '0;
         dmem_valid_q  <= 1'b0;
         dmem_wen_q    <= 1'b0;
         dmem_addr_q   <= '0;
         dmem_wstrb_q  <= '0;
         dmem_wdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         resp_valid_q  <= resp_valid_d;
         err_q         <= err_d;
         rdata_q       <= rdata_d;
         clint_ren_q   <= clint_ren_d;
         clint_wen_q   <= clint_wen_d;
         clint_addr_q  <= clint_addr_d;
         clint_wdata_q <= clint_wdata_d;
         dmem_valid_q  <= dmem_valid_d;
         dmem_wen_q    <= dmem_wen_d;
         dmem_addr_q   <= dmem_addr_d;
         dmem_wstrb_q  <= dmem_wstrb_d;
         dmem_wdata_q  <= dmem_wdata_d;
      end
   end

   assign lsu_req_ready_o  = ready_q;
   assign lsu_resp_valid_o = resp_valid_q;
   assign lsu_resp_err_o   = err_q;
   assign lsu_rdata_o      = rdata_q;
   assign clint_ren_o      = clint_ren_q;
   assign clint_wen_o      = clint_wen_q;
   assign clint_rwaddr_o   = clint_addr_q;
   assign clint_wdata_o    = clint_wdata_q;
   assign dmem_req_valid_o = dmem_valid_q;
   assign dmem_wen_o       = dmem_wen_q;
   assign dmem_addr_o      = dmem_addr_q;
   assign dmem_wstrb_o     = dmem_wstrb_q;
   assign dmem_wdata_o     = dmem_wdata_q;

endmodule
